// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: control, target and status signals between the core FSM/ALU and pc_ctrl_unit.
interface pc_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int HIST_DEPTH = 4
);
    localparam int HW = $clog2(HIST_DEPTH);
    logic             pc_write;
    logic             pc_write_cond;
    logic             branch_ne;
    logic             alu_zero;
    logic [1:0]       pc_src;
    logic [WIDTH-1:0] br_target;
    logic [25:0]      j_index;
    logic [WIDTH-1:0] jr_addr;
    logic             exc_req;
    logic             eret;
    logic [HW-1:0]    hist_idx;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] epc_out;
    logic             addr_err;
    logic             pc_changed;
    logic [WIDTH-1:0] hist_data;
    modport master (
        output pc_write, pc_write_cond, branch_ne, alu_zero, pc_src, br_target, j_index, jr_addr, exc_req, eret, hist_idx,
        input  pc_out, pc_plus4, epc_out, addr_err, pc_changed, hist_data
    );
    modport slave (
        input  pc_write, pc_write_cond, branch_ne, alu_zero, pc_src, br_target, j_index, jr_addr, exc_req, eret, hist_idx,
        output pc_out, pc_plus4, epc_out, addr_err, pc_changed, hist_data
    );
endinterface

// File: rtl/pc_ctrl_unit.sv
// pc_ctrl_unit: multicycle MIPS PC with next-PC select, EPC capture, jr trap and optional PC_HIST_EN debug history.
module pc_ctrl_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VEC  = 32'h00400000,
    parameter logic [WIDTH-1:0] EXC_VEC    = 32'h80000180,
    parameter int               HIST_DEPTH = 4
) (
    input logic     clk,
    input logic     rst,
    pc_ctrl_if.slave bus
);
    localparam int HW = $clog2(HIST_DEPTH);
    logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d, pc_plus4, jump_tgt, src_tgt;
    logic             addr_err_q, addr_err_d, pc_changed_q, pc_changed_d;
    logic             take, jr_bad, trap, upd;
    always_comb begin
        pc_plus4     = pc_q + WIDTH'(4);
        jump_tgt     = (pc_plus4 & ~WIDTH'(28'hFFFFFFF)) | WIDTH'({bus.j_index, 2'b00});
        take         = bus.pc_write | (bus.pc_write_cond & (bus.alu_zero ^ bus.branch_ne));
        jr_bad       = take & (bus.pc_src == 2'd3) & (bus.jr_addr[1:0] != 2'b00);
        trap         = bus.exc_req | jr_bad;
        upd          = trap | bus.eret | take;
        src_tgt      = bus.pc_src == 2'd0 ? pc_plus4 :
                       bus.pc_src == 2'd1 ? bus.br_target :
                       bus.pc_src == 2'd2 ? jump_tgt : bus.jr_addr;
        pc_d         = trap ? EXC_VEC : bus.eret ? epc_q : take ? src_tgt : pc_q;
        epc_d        = trap ? pc_q : epc_q;
        addr_err_d   = jr_bad & ~bus.exc_req;
        pc_changed_d = upd;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_VEC;
            epc_q        <= '0;
            addr_err_q   <= 1'b0;
            pc_changed_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            addr_err_q   <= addr_err_d;
            pc_changed_q <= pc_changed_d;
        end
    end
    assign bus.pc_out     = pc_q;
    assign bus.pc_plus4   = pc_plus4;
    assign bus.epc_out    = epc_q;
    assign bus.addr_err   = addr_err_q;
    assign bus.pc_changed = pc_changed_q;
`ifdef PC_HIST_EN
    logic [WIDTH-1:0] hist_q [HIST_DEPTH];
    logic [WIDTH-1:0] hist_d [HIST_DEPTH];
    logic [HW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr;
    always_comb begin
        hist_d           = hist_q;
        hist_d[wr_ptr_q] = upd ? pc_q : hist_q[wr_ptr_q];
        wr_ptr_d         = upd ? wr_ptr_q + HW'(1) : wr_ptr_q;
        rd_ptr           = wr_ptr_q - HW'(1) - bus.hist_idx;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q   <= '{default: '0};
            wr_ptr_q <= '0;
        end else begin
            hist_q   <= hist_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end
    assign bus.hist_data = hist_q[rd_ptr];
`else
    logic unused_hist;
    assign unused_hist   = ^bus.hist_idx;
    assign bus.hist_data = '0;
`endif
endmodule

// File: tb/tb_pc_ctrl_unit.sv
// tb_pc_ctrl_unit: directed vector table plus reset, async-reset and history sequences for pc_ctrl_unit.
module tb_pc_ctrl_unit;
    typedef struct {
        logic [3:0]  ctl;
        logic [1:0]  src;
        logic [31:0] br;
        logic [25:0] ji;
        logic [31:0] jr;
        logic [1:0]  ev;
        logic [31:0] e_pc;
        logic [31:0] e_epc;
        logic [1:0]  e_f;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[25];
    logic [31:0] hexp[4];
    pc_ctrl_if #(.WIDTH(32), .HIST_DEPTH(4)) bus ();
    pc_ctrl_unit dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic idle();
        bus.pc_write = 1'b0; bus.pc_write_cond = 1'b0; bus.branch_ne = 1'b0; bus.alu_zero = 1'b0;
        bus.pc_src = 2'd0; bus.br_target = '0; bus.j_index = '0; bus.jr_addr = '0;
        bus.exc_req = 1'b0; bus.eret = 1'b0; bus.hist_idx = '0;
    endtask
    initial begin
        vecs[0]  = '{4'b1000, 2'd0, 32'h0,        26'h0,       32'h0,        2'b00, 32'h00400004, 32'h0,        2'b01};
        vecs[1]  = '{4'b1000, 2'd0, 32'h0,        26'h0,       32'h0,        2'b00, 32'h00400008, 32'h0,        2'b01};
        vecs[2]  = '{4'b1000, 2'd0, 32'h0,        26'h0,       32'h0,        2'b00, 32'h0040000C, 32'h0,        2'b01};
        vecs[3]  = '{4'b0000, 2'd0, 32'h0,        26'h0,       32'h0,        2'b00, 32'h0040000C, 32'h0,        2'b00};
        vecs[4]  = '{4'b1000, 2'd0, 32'h0,        26'h0,       32'h0,        2'b00, 32'h00400010, 32'h0,        2'b01};
        vecs[5]  = '{4'b0101, 2'd1, 32'h00400040, 26'h0,       32'h0,        2'b00, 32'h00400040, 32'h0,        2'b01};
        vecs[6]  = '{4'b0111, 2'd1, 32'h00400080, 26'h0,       32'h0,        2'b00, 32'h00400040, 32'h0,        2'b00};
        vecs[7]  = '{4'b0110, 2'd1, 32'h00400082, 26'h0,       32'h0,        2'b00, 32'h00400082, 32'h0,        2'b01};
        vecs[8]  = '{4'b0100, 2'd1, 32'h00400090, 26'h0,       32'h0,        2'b00, 32'h00400082, 32'h0,        2'b00};
        vecs[9]  = '{4'b1000, 2'd3, 32'h0,        26'h0,       32'h00400020, 2'b00, 32'h00400020, 32'h0,        2'b01};
        vecs[10] = '{4'b1000, 2'd2, 32'h0,        26'h0100010, 32'h0,        2'b00, 32'h00400040, 32'h0,        2'b01};
        vecs[11] = '{4'b1000, 2'd3, 32'h0,        26'h0,       32'h00400101, 2'b00, 32'h80000180, 32'h00400040, 2'b11};
        vecs[12] = '{4'b0000, 2'd0, 32'h0,        26'h0,       32'h0,        2'b00, 32'h80000180, 32'h00400040, 2'b00};
        vecs[13] = '{4'b0000, 2'd0, 32'h0,        26'h0,       32'h0,        2'b01, 32'h00400040, 32'h00400040, 2'b01};
        vecs[14] = '{4'b1000, 2'd3, 32'h0,        26'h0,       32'h00400050, 2'b00, 32'h00400050, 32'h00400040, 2'b01};
        vecs[15] = '{4'b1000, 2'd0, 32'h0,        26'h0,       32'h0,        2'b11, 32'h80000180, 32'h00400050, 2'b01};
        vecs[16] = '{4'b0000, 2'd0, 32'h0,        26'h0,       32'h0,        2'b01, 32'h00400050, 32'h00400050, 2'b01};
        vecs[17] = '{4'b1100, 2'd1, 32'h00400100, 26'h0,       32'h0,        2'b00, 32'h00400100, 32'h00400050, 2'b01};
        vecs[18] = '{4'b0101, 2'd3, 32'h0,        26'h0,       32'h00400102, 2'b00, 32'h80000180, 32'h00400100, 2'b11};
        vecs[19] = '{4'b1000, 2'd3, 32'h0,        26'h0,       32'h00400003, 2'b10, 32'h80000180, 32'h80000180, 2'b01};
        vecs[20] = '{4'b0000, 2'd0, 32'h0,        26'h0,       32'h0,        2'b01, 32'h80000180, 32'h80000180, 2'b01};
        vecs[21] = '{4'b1000, 2'd3, 32'h0,        26'h0,       32'hFFFFFFFC, 2'b00, 32'hFFFFFFFC, 32'h80000180, 2'b01};
        vecs[22] = '{4'b1000, 2'd0, 32'h0,        26'h0,       32'h0,        2'b00, 32'h00000000, 32'h80000180, 2'b01};
        vecs[23] = '{4'b1000, 2'd2, 32'h0,        26'h3FFFFFF, 32'h0,        2'b00, 32'h0FFFFFFC, 32'h80000180, 2'b01};
        vecs[24] = '{4'b1000, 2'd2, 32'h0,        26'h0000001, 32'h0,        2'b00, 32'h10000004, 32'h80000180, 2'b01};
`ifdef PC_HIST_EN
        hexp = '{32'h00400014, 32'h00400010, 32'h0040000C, 32'h00400008};
`else
        hexp = '{32'h0, 32'h0, 32'h0, 32'h0};
`endif
        idle();
        bus.pc_write = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("reset pc", bus.pc_out, 32'h00400000);
            chk("reset chg", 32'(bus.pc_changed), 32'h0);
        end
        chk("reset epc", bus.epc_out, 32'h0);
        chk("reset aerr", 32'(bus.addr_err), 32'h0);
        chk("reset hist", bus.hist_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        idle();
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            {bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.alu_zero} = vecs[i].ctl;
            bus.pc_src = vecs[i].src; bus.br_target = vecs[i].br; bus.j_index = vecs[i].ji;
            bus.jr_addr = vecs[i].jr; {bus.exc_req, bus.eret} = vecs[i].ev;
            @(posedge clk); #1;
            chk($sformatf("v%0d pc", i), bus.pc_out, vecs[i].e_pc);
            chk($sformatf("v%0d plus4", i), bus.pc_plus4, vecs[i].e_pc + 32'd4);
            chk($sformatf("v%0d epc", i), bus.epc_out, vecs[i].e_epc);
            chk($sformatf("v%0d aerr", i), 32'(bus.addr_err), 32'(vecs[i].e_f[1]));
            chk($sformatf("v%0d chg", i), 32'(bus.pc_changed), 32'(vecs[i].e_f[0]));
        end
        @(negedge clk);
        idle();
        bus.pc_write = 1'b1;
        @(posedge clk); #1;
        chk("burst pc", bus.pc_out, 32'h10000008);
        #2 rst = 1'b0;
        #1;
        chk("async pc", bus.pc_out, 32'h00400000);
        chk("async epc", bus.epc_out, 32'h0);
        chk("async chg", 32'(bus.pc_changed), 32'h0);
        @(posedge clk); #1;
        chk("held pc", bus.pc_out, 32'h00400000);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("seq%0d pc", k), bus.pc_out, 32'h00400000 + 32'(4 * (k + 1)));
        end
        @(negedge clk);
        bus.pc_write = 1'b0;
        @(posedge clk); #1;
        chk("idle chg", 32'(bus.pc_changed), 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus.hist_idx = 2'(i);
            #1;
            chk($sformatf("hist%0d", i), bus.hist_data, hexp[i]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_ctrl_unit.md
Name: pc_ctrl_unit

Overview:
- Parametrised program-counter unit for the multicycle MIPS core. Generalises the plain PC register with the following:
  - clocked update
  - internal next-PC selection (sequential, branch, jump, jr, exception, eret)
  - conditional branch write
  - EPC capture
  - jr misalignment trap
  - optional PC history buffer for debug
- Sits between the control FSM / ALU and the instruction-memory address mux.

Parameters:
- WIDTH, 32, PC/data width; must be >= 28.
- RESET_VEC, 32'h00400000, PC value loaded on reset.
- EXC_VEC, 32'h80000180, PC value loaded on exception or address error.
- HIST_DEPTH, 4, number of history entries (power of 2, >= 2); used only with PC_HIST_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- pc_write  in  1  unconditional PC update enable.
- pc_write_cond  in  1  branch update enable; the update is qualified by alu_zero/branch_ne.
- branch_ne  in  1  0 = beq semantics (take if alu_zero = 1); 1 = bne semantics (take if alu_zero = 0).
- alu_zero  in  1  ALU zero flag.
- pc_src  in  2  0 = pc+4, 1 = br_target, 2 = jump, 3 = jr_addr.
- br_target  in  WIDTH  branch target computed by the ALU.
- j_index  in  26  jump instruction index field.
- jr_addr  in  WIDTH  register value for jr.
- exc_req  in  1  exception request, one-cycle pulse.
- eret  in  1  return from exception.
- hist_idx  in  log2(HIST_DEPTH)  history read index; 0 = most recent entry.
- pc_out  out  WIDTH  current PC.
- pc_plus4  out  WIDTH  pc_out + 4, combinational.
- epc_out  out  WIDTH  saved exception PC.
- addr_err  out  1  one-cycle pulse when a jr target is misaligned.
- pc_changed  out  1  one-cycle pulse, asserted the cycle after any PC update.
- hist_data  out  WIDTH  history read data.

Behaviour:
- Reset (rst = 0, asynchronous):
  - pc_out = RESET_VEC
  - epc_out = 0
  - addr_err = 0
  - pc_changed = 0
  - history cleared to 0; write pointer = 0
- Reset release is synchronous to the next clk edge.
- Reset asserted mid-update overrides any pending write.
- pc_plus4 = pc_out + 4, modulo 2^WIDTH; it wraps silently.
- Jump target = {pc_plus4[WIDTH-1:28], j_index, 2'b00}.
- take = pc_write | (pc_write_cond & (alu_zero ^ branch_ne)).
- Priority per rising edge, highest first:
  1. exc_req: epc <= pc_out; pc <= EXC_VEC. Ignores pc_write, eret and pc_src.
  2. take with pc_src = 3 and jr_addr[1:0] != 0: epc <= pc_out; pc <= EXC_VEC; addr_err = 1 next cycle.
  3. eret: pc <= epc_out; epc unchanged.
  4. take: pc <= mux(pc_src).
  5. Otherwise: hold.
- pc_changed = 1 for exactly one cycle after any of cases 1-4, even if the new value equals the old one.
- addr_err is registered and self-clears after one cycle.
- Single-cycle update latency: a value selected at edge N appears on pc_out after edge N.
- pc_write and pc_write_cond both high: behaves as pc_write.
- pc_write_cond high with the condition false and no other event: hold, no pc_changed.
- Branch targets are not alignment-checked; only jr is checked.

Optional Feature:
- Macro: PC_HIST_EN.
- Defined:
  - On every PC update (cases 1-4), the old pc_out is written into a circular buffer of HIST_DEPTH entries at wr_ptr, and wr_ptr increments, wrapping at HIST_DEPTH.
  - hist_data = buf[wr_ptr - 1 - hist_idx] (mod HIST_DEPTH), combinational.
  - Once the buffer wraps, the oldest entries are overwritten.
- Not defined:
  - No buffer storage is instantiated.
  - hist_data is tied to 0.
  - The hist_idx port remains and is ignored.

Test Plan:
- Reset sequence: hold rst = 0 with pc_write = 1 → pc_out = 32'h00400000, pc_changed = 0. Release rst, then 3 cycles of pc_write with pc_src = 0 → pc_out = 00400004, 00400008, 0040000C, each followed by a pc_changed pulse.
- Branches, with pc = 00400010 and br_target = 00400040:
  - pc_write_cond = 1, alu_zero = 1, branch_ne = 0 → pc = 00400040.
  - alu_zero = 1, branch_ne = 1 → pc holds, no pc_changed.
- Jump and jr:
  - pc = 00400020, j_index = 26'h0100010 → pc = 00400040.
  - jr_addr = 00400101 → pc = 80000180, epc = previous pc, addr_err pulses once.
- Exception priority: exc_req = 1, eret = 1 and pc_write = 1 in the same cycle at pc = 00400050 → pc = 80000180, epc = 00400050. Then eret alone → pc = 00400050.
- Async reset mid-operation: drop rst between clock edges during a pc_write burst → pc_out = 00400000 immediately (no edge required), epc = 0.
- PC_HIST_EN wrap: 6 sequential updates from 00400000 with HIST_DEPTH = 4 → hist_idx 0..3 reads 00400014, 00400010, 0040000C, 00400008. With the macro undefined, hist_data = 0.
